// File: rtl/tc_ram_line_adapter.sv
// rtl/tc_ram_line_adapter.sv - word-wide CPU port adapted onto a 4-word line RAM with read-merge-write stores
module tc_ram_line_adapter #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    BIT_WIDTH = 16,
    parameter int    TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_load,
    input  logic                 cpu_save,
    input  logic [15:0]          cpu_address,
    input  logic [BIT_WIDTH-1:0] cpu_wdata,
    output logic                 cpu_busy,
    output logic                 cpu_rvalid,
    output logic [BIT_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_done,
    output logic                 cpu_err,
    output logic                 ram_load,
    output logic                 ram_save,
    output logic [15:0]          ram_address,
    output logic [BIT_WIDTH-1:0] ram_in0,
    output logic [BIT_WIDTH-1:0] ram_in1,
    output logic [BIT_WIDTH-1:0] ram_in2,
    output logic [BIT_WIDTH-1:0] ram_in3,
    input  logic                 ram_ready,
    input  logic [BIT_WIDTH-1:0] ram_out0,
    input  logic [BIT_WIDTH-1:0] ram_out1,
    input  logic [BIT_WIDTH-1:0] ram_out2,
    input  logic [BIT_WIDTH-1:0] ram_out3
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_SAVE  = 2'd3
    } state_t;

    typedef logic [3:0][BIT_WIDTH-1:0] line_t;

    // Wait counter value on the last RD_WAIT cycle allowed before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 is_store_q, is_store_d;
    logic [1:0]           idx_q, idx_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]          addr_q, addr_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    line_t                line_q, line_d;
    logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    line_t ram_line;
    logic  req_any;
    logic  timeout_hit;
    logic  unused_params;

    assign ram_line      = {ram_out3, ram_out2, ram_out1, ram_out0};
    assign req_any       = cpu_load | cpu_save;
    assign timeout_hit   = (wait_cnt_q == TIMEOUT_LAST);
    assign unused_params = (UUID == 0) ^ (NAME == "");

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            idx_q      <= 2'd0;
            wdata_q    <= '0;
            addr_q     <= 16'd0;
            wait_cnt_q <= 8'd0;
            line_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            line_q     <= line_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state: every op reads the line first; stores then write the merged line back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (ram_ready) begin
                    state_d = is_store_q ? WR_SAVE : IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WR_SAVE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: request capture, wait counting, line merge and completion pulses.
    always_comb begin
        is_store_d = is_store_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        line_d     = line_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    // A simultaneous load and save is a store.
                    is_store_d = cpu_save;
                    idx_d      = cpu_address[1:0];
                    wdata_d    = cpu_wdata;
                    addr_d     = {cpu_address[15:2], 2'b00};
                end
            end
            RD_ISSUE: begin
                wait_cnt_d = 8'd0;
            end
            RD_WAIT: begin
                if (ram_ready) begin
                    if (is_store_q) begin
                        line_d        = ram_line;
                        line_d[idx_q] = wdata_q;
                    end else begin
                        rdata_d  = ram_line[idx_q];
                        rvalid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    // Abandon the op; nothing is written back.
                    err_d      = 1'b1;
                    is_store_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            WR_SAVE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Outputs: strobes decode from state, write data exposed only while saving.
    always_comb begin
        cpu_busy    = (state_q != IDLE);
        ram_load    = (state_q == RD_ISSUE);
        ram_save    = (state_q == WR_SAVE);
        ram_address = addr_q;
        cpu_rdata   = rdata_q;
        cpu_rvalid  = rvalid_q;
        cpu_done    = done_q;
        cpu_err     = err_q;
        ram_in0     = '0;
        ram_in1     = '0;
        ram_in2     = '0;
        ram_in3     = '0;
        if (state_q == WR_SAVE) begin
            ram_in0 = line_q[0];
            ram_in1 = line_q[1];
            ram_in2 = line_q[2];
            ram_in3 = line_q[3];
        end
    end

endmodule

// File: tb/tb_tc_ram_line_adapter.sv
// tb/tb_tc_ram_line_adapter.sv - randomized scoreboard bench for tc_ram_line_adapter
module tb_tc_ram_line_adapter;

    localparam int TMO = 15;

    localparam int K_LOAD   = 0;
    localparam int K_RVALID = 1;
    localparam int K_SAVE   = 2;
    localparam int K_DONE   = 3;
    localparam int K_ERR    = 4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic [15:0] addr;
        logic [63:0] line;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_load = 1'b0;
    logic        cpu_save = 1'b0;
    logic [15:0] cpu_address = 16'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic        cpu_busy, cpu_rvalid, cpu_done, cpu_err;
    logic [15:0] cpu_rdata;
    logic        ram_load, ram_save;
    logic [15:0] ram_address;
    logic [15:0] ram_in0, ram_in1, ram_in2, ram_in3;
    logic        ram_ready = 1'b0;
    logic [15:0] ram_out0 = 16'd0, ram_out1 = 16'd0, ram_out2 = 16'd0, ram_out3 = 16'd0;

    tc_ram_line_adapter #(
        .UUID(0), .NAME(""), .BIT_WIDTH(16), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_load(cpu_load), .cpu_save(cpu_save), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err),
        .ram_load(ram_load), .ram_save(ram_save), .ram_address(ram_address),
        .ram_in0(ram_in0), .ram_in1(ram_in1), .ram_in2(ram_in2), .ram_in3(ram_in3),
        .ram_ready(ram_ready),
        .ram_out0(ram_out0), .ram_out1(ram_out1), .ram_out2(ram_out2), .ram_out3(ram_out3)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;
    int          ram_lat = 2;
    logic [15:0] ram_mem [64];
    logic [15:0] ref_mem [64];
    logic [15:0] hold_exp = 16'd0;
    exp_t        exp_q [$];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Line RAM model: answers each ram_load after ram_lat edges (0 = never), commits ram_save, and injects stray ready while idle.
    initial begin
        forever begin
            @(posedge clk);
            if (ram_save === 1'b1) begin
                ram_mem[ram_address[5:0]]      = ram_in0;
                ram_mem[ram_address[5:0] + 1]  = ram_in1;
                ram_mem[ram_address[5:0] + 2]  = ram_in2;
                ram_mem[ram_address[5:0] + 3]  = ram_in3;
            end
            if (ram_load === 1'b1) begin
                if (ram_lat != 0) begin
                    repeat (ram_lat - 1) @(posedge clk);
                    #1;
                    ram_out0  = ram_mem[ram_address[5:0]];
                    ram_out1  = ram_mem[ram_address[5:0] + 1];
                    ram_out2  = ram_mem[ram_address[5:0] + 2];
                    ram_out3  = ram_mem[ram_address[5:0] + 3];
                    ram_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    ram_ready = 1'b0;
                    ram_out0  = 16'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                #1;
                if (cpu_busy === 1'b0) begin
                    ram_out0  = 16'($urandom);
                    ram_out1  = 16'($urandom);
                    ram_out2  = 16'($urandom);
                    ram_out3  = 16'($urandom);
                    ram_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    ram_ready = 1'b0;
                end
            end
        end
    end

    task automatic check_ev(input int kind);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d, required no event", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (int'(e.kind) != kind || int'(e.cyc) != cyc) begin
            miscompares++;
            $display("FAIL event_timing got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                     kind, cyc, e.kind, e.cyc);
            return;
        end
        case (kind)
            K_LOAD: begin
                if (ram_address !== e.addr) begin
                    miscompares++;
                    $display("FAIL ram_address got %h, required %h", ram_address, e.addr);
                end
            end
            K_RVALID: begin
                if (cpu_rdata !== e.line[15:0]) begin
                    miscompares++;
                    $display("FAIL cpu_rdata got %h, required %h", cpu_rdata, e.line[15:0]);
                end
                hold_exp = e.line[15:0];
            end
            K_SAVE: begin
                if (ram_address !== e.addr || {ram_in3, ram_in2, ram_in1, ram_in0} !== e.line) begin
                    miscompares++;
                    $display("FAIL ram_save_line got addr=%h line=%h, required addr=%h line=%h",
                             ram_address, {ram_in3, ram_in2, ram_in1, ram_in0}, e.addr, e.line);
                end
            end
            default: begin
            end
        endcase
    endtask

    // Monitor: compares every DUT event against the head of the expectation queue.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                vectors++;
                hold_exp = 16'd0;
                if ({cpu_busy, cpu_rvalid, cpu_done, cpu_err, ram_load, ram_save} !== 6'd0 ||
                    ram_address !== 16'd0 || cpu_rdata !== 16'd0 ||
                    {ram_in3, ram_in2, ram_in1, ram_in0} !== 64'd0) begin
                    miscompares++;
                    $display("FAIL reset_outputs got busy=%b rv=%b done=%b err=%b ld=%b sv=%b addr=%h rdata=%h, required all zero",
                             cpu_busy, cpu_rvalid, cpu_done, cpu_err, ram_load, ram_save, ram_address, cpu_rdata);
                end
            end else begin
                if (ram_load) check_ev(K_LOAD);
                if (cpu_rvalid) begin
                    check_ev(K_RVALID);
                end else begin
                    vectors++;
                    if (cpu_rdata !== hold_exp) begin
                        miscompares++;
                        $display("FAIL rdata_hold got %h, required %h", cpu_rdata, hold_exp);
                    end
                end
                if (ram_save) begin
                    check_ev(K_SAVE);
                end else if ({ram_in3, ram_in2, ram_in1, ram_in0} !== 64'd0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ram_in_idle got %h, required 0", {ram_in3, ram_in2, ram_in1, ram_in0});
                end
                if (cpu_done) check_ev(K_DONE);
                if (cpu_err) check_ev(K_ERR);
            end
        end
    end

    function automatic exp_t mk(input int kind, input int c, input logic [15:0] a, input logic [63:0] l);
        exp_t e;
        e.kind = 3'(kind);
        e.cyc  = 32'(c);
        e.addr = a;
        e.line = l;
        return e;
    endfunction

    // Issues one request once the adapter is free and queues the responses the reference model predicts.
    task automatic do_op(input bit st, input bit both, input logic [15:0] a, input logic [15:0] wd,
                         input int lat, input bit rst_mid);
        int          n;
        int          k;
        int          base;
        int          idx;
        logic [63:0] line;
        n = 0;
        while (cpu_busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait got busy=%b, required 0 within 200 cycles", cpu_busy);
        end
        ram_lat     = lat;
        cpu_load    = !st || both;
        cpu_save    = st;
        cpu_address = a;
        cpu_wdata   = wd;
        @(posedge clk);
        #1;
        k    = cyc;
        base = int'(a[5:2]) * 4;
        idx  = int'(a[1:0]);
        line = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
        exp_q.push_back(mk(K_LOAD, k, {a[15:2], 2'b00}, 64'd0));
        if (rst_mid) begin
            cpu_load = 1'b0;
            cpu_save = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            return;
        end
        if (lat == 0) begin
            exp_q.push_back(mk(K_ERR, k + 1 + TMO, 16'd0, 64'd0));
        end else if (!st) begin
            exp_q.push_back(mk(K_RVALID, k + 1 + lat, 16'd0, {48'd0, ref_mem[base + idx]}));
        end else begin
            ref_mem[base + idx] = wd;
            line = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
            exp_q.push_back(mk(K_SAVE, k + 1 + lat, {a[15:2], 2'b00}, line));
            exp_q.push_back(mk(K_DONE, k + 2 + lat, 16'd0, 64'd0));
        end
        n = 0;
        while (cpu_busy === 1'b1 && n < 100) begin
            cpu_load    = 1'($urandom);
            cpu_save    = 1'($urandom);
            cpu_address = 16'($urandom_range(0, 63));
            cpu_wdata   = 16'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        cpu_load = 1'b0;
        cpu_save = 1'b0;
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog got no finish, required finish within 30000 cycles");
        $fatal(1);
    end

    initial begin
        int bad;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'($urandom);
        end
        ref_mem[16] = 16'h000A; ref_mem[17] = 16'h000B; ref_mem[18] = 16'h000C; ref_mem[19] = 16'h000D;
        ref_mem[4]  = 16'h0001; ref_mem[5]  = 16'h0002; ref_mem[6]  = 16'h0003; ref_mem[7]  = 16'h0004;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(1'b0, 1'b0, 16'h0012, 16'h0000, 2, 1'b0);
        do_op(1'b1, 1'b0, 16'h0007, 16'hBEEF, 2, 1'b0);
        do_op(1'b0, 1'b0, 16'h0007, 16'h0000, 3, 1'b0);
        do_op(1'b1, 1'b1, 16'h0000, 16'h5555, 2, 1'b0);
        do_op(1'b0, 1'b0, 16'h0021, 16'h0000, 0, 1'b0);
        do_op(1'b1, 1'b0, 16'h0013, 16'h1234, 4, 1'b1);
        do_op(1'b0, 1'b0, 16'h0013, 16'h0000, 1, 1'b0);
        do_op(1'b0, 1'b0, 16'h003F, 16'h0000, 6, 1'b0);
        for (int i = 0; i < 60; i++) begin
            bit st;
            st = 1'($urandom);
            do_op(st, st && ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 63)), 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
                  ($urandom_range(0, 15) == 0));
        end
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (ram_mem[i] !== ref_mem[i]) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL ram_contents got %0d differing words, required 0", bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
